// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, ALUOp codes, R-type funct constants and ALU
// operation encodings for the ID/EX stage and its ALU-control decoder.
package mips_pkg;

    localparam int DW = 32;   // datapath width
    localparam int RW = 5;    // register-index width

    // ALUOp as produced by the main decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    // R-type funct field values understood by the ALU
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // 3-bit ALU operation select
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

endpackage

// File: rtl/alu_control.sv
// alu_control: combinational ALUOp/funct -> ALU operation decoder.
// Ports:
//   alu_op    in  2  ALUOp from the main decoder
//   funct     in  6  instr[5:0]
//   operation out 3  ALU operation select
//   illegal   out 1  R-type with a funct the ALU does not implement
//                    (raw; the caller qualifies it with instruction validity)
module alu_control (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] operation,
    output logic       illegal
);
    import mips_pkg::*;

    always_comb begin
        operation = OP_ADD;
        illegal   = 1'b0;
        case (aluop_e'(alu_op))
            ALUOP_ADD: operation = OP_ADD;
            ALUOP_SUB: operation = OP_SUB;
            ALUOP_OR:  operation = OP_OR;
            default: begin
                case (funct)
                    FN_ADD:  operation = OP_ADD;
                    FN_SUB:  operation = OP_SUB;
                    FN_AND:  operation = OP_AND;
                    FN_OR:   operation = OP_OR;
                    FN_SLT:  operation = OP_SLT;
                    default: begin
                        // unknown funct falls back to add so the ALU output stays defined
                        operation = OP_ADD;
                        illegal   = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus EX-side operand preparation.
// Captures decoded fields each cycle (flush > hold > load), decodes the ALU
// operation from the registered ALUOp/funct, resolves EX/MEM and MEM/WB
// forwarding onto the ALU operands and flags load-use hazards.
// Ports:
//   clk, rst_n              clock (rising) / async active-low reset
//   hold, flush             freeze contents / insert bubble on next edge
//   id_*                    decoded instruction fields from ID
//   exmem_*, memwb_*        forwarding sources (write enable, index, value)
//   alu_a, alu_b            ALU operands
//   alu_operation           3-bit ALU select; ex_illegal flags bad R-type funct
//   ex_store_data           forwarded rt value for stores
//   ex_dest                 selected destination register index
//   ex_valid, ex_* controls registered control bits
//   load_use_hazard         EX load targets a register the ID instruction reads
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [1:0]    id_alu_op,
    input  logic [5:0]    id_funct,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          id_branch,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_operation,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          ex_branch,
    output logic          ex_illegal,
    output logic          load_use_hazard
);
    import mips_pkg::*;

    logic          vld_p1;
    logic          reg_write_p1, mem_read_p1, mem_write_p1, mem_to_reg_p1, branch_p1;
    logic          alu_src_p1;
    logic [1:0]    alu_op_p1;
    logic [5:0]    funct_p1;
    logic [DW-1:0] rs_data_p1, rt_data_p1, imm_p1;
    logic [RW-1:0] rs_p1, rt_p1, dest_p1;

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1        <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            branch_p1     <= 1'b0;
            alu_src_p1    <= 1'b0;
            alu_op_p1     <= '0;
            funct_p1      <= '0;
            rs_data_p1    <= '0;
            rt_data_p1    <= '0;
            imm_p1        <= '0;
            rs_p1         <= '0;
            rt_p1         <= '0;
            dest_p1       <= '0;
        end else if (flush) begin
            vld_p1        <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            branch_p1     <= 1'b0;
            alu_src_p1    <= 1'b0;
            alu_op_p1     <= '0;
            funct_p1      <= '0;
            rs_data_p1    <= '0;
            rt_data_p1    <= '0;
            imm_p1        <= '0;
            rs_p1         <= '0;
            rt_p1         <= '0;
            dest_p1       <= '0;
        end else if (!hold) begin
            // a bubble (id_valid=0) still moves data but never any side-effecting control
            vld_p1        <= id_valid;
            reg_write_p1  <= id_valid & id_reg_write;
            mem_read_p1   <= id_valid & id_mem_read;
            mem_write_p1  <= id_valid & id_mem_write;
            mem_to_reg_p1 <= id_valid & id_mem_to_reg;
            branch_p1     <= id_valid & id_branch;
            alu_src_p1    <= id_alu_src;
            alu_op_p1     <= id_alu_op;
            funct_p1      <= id_funct;
            rs_data_p1    <= id_rs_data;
            rt_data_p1    <= id_rt_data;
            imm_p1        <= id_imm;
            rs_p1         <= id_rs;
            rt_p1         <= id_rt;
            dest_p1       <= id_reg_dst ? id_rd : id_rt;
        end
    end

    // Most recent producer wins; register 0 is hardwired and never forwarded.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] src,
        input logic [DW-1:0] regval,
        input logic          em_we,
        input logic [RW-1:0] em_rd,
        input logic [DW-1:0] em_val,
        input logic          mw_we,
        input logic [RW-1:0] mw_rd,
        input logic [DW-1:0] mw_val
    );
        if (em_we && (em_rd != '0) && (em_rd == src))
            return em_val;
        else if (mw_we && (mw_rd != '0) && (mw_rd == src))
            return mw_val;
        else
            return regval;
    endfunction

    logic [DW-1:0] fwd_a, fwd_b;
    logic          illegal_raw;

    assign fwd_a = fwd_sel(rs_p1, rs_data_p1, exmem_reg_write, exmem_rd, exmem_result,
                           memwb_reg_write, memwb_rd, memwb_result);
    assign fwd_b = fwd_sel(rt_p1, rt_data_p1, exmem_reg_write, exmem_rd, exmem_result,
                           memwb_reg_write, memwb_rd, memwb_result);

    alu_control u_alu_control (
        .alu_op    (alu_op_p1),
        .funct     (funct_p1),
        .operation (alu_operation),
        .illegal   (illegal_raw)
    );

    assign alu_a         = fwd_a;
    assign alu_b         = alu_src_p1 ? imm_p1 : fwd_b;
    assign ex_store_data = fwd_b;
    assign ex_dest       = dest_p1;
    assign ex_valid      = vld_p1;
    assign ex_reg_write  = reg_write_p1;
    assign ex_mem_read   = mem_read_p1;
    assign ex_mem_write  = mem_write_p1;
    assign ex_mem_to_reg = mem_to_reg_p1;
    assign ex_branch     = branch_p1;
    assign ex_illegal    = illegal_raw & vld_p1;

    // compares against the live ID indices, so it stays meaningful while held
    assign load_use_hazard = mem_read_p1 & vld_p1 & (dest_p1 != '0) &
                             ((dest_p1 == id_rs) | (dest_p1 == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, hold, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_operation;
    logic [4:0]  ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic        ex_illegal, load_use_hazard;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_illegal(ex_illegal), .load_use_hazard(load_use_hazard)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: the instruction sitting in EX ----------------
    typedef struct {
        bit        v, rw, mr, mw, m2r, br, src;
        bit [1:0]  aop;
        bit [5:0]  fn;
        bit [31:0] rsd, rtd, imm;
        bit [4:0]  rs, rt, dest;
    } ex_t;

    ex_t m;
    ex_t empty_ex;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            m = empty_ex;
        end else if (!hold) begin
            m.v   = id_valid;
            m.rw  = id_valid && id_reg_write;
            m.mr  = id_valid && id_mem_read;
            m.mw  = id_valid && id_mem_write;
            m.m2r = id_valid && id_mem_to_reg;
            m.br  = id_valid && id_branch;
            m.src = id_alu_src;
            m.aop = id_alu_op;
            m.fn  = id_funct;
            m.rsd = id_rs_data;
            m.rtd = id_rt_data;
            m.imm = id_imm;
            m.rs  = id_rs;
            m.rt  = id_rt;
            m.dest = id_reg_dst ? id_rd : id_rt;
        end
    end

    function automatic bit [31:0] value_of(input bit [4:0] r, input bit [31:0] regval);
        if (r == 0) return regval;
        if (exmem_reg_write && exmem_rd == r) return exmem_result;
        if (memwb_reg_write && memwb_rd == r) return memwb_result;
        return regval;
    endfunction

    function automatic bit [2:0] op_of(input bit [1:0] aop, input bit [5:0] fn);
        if (aop == 2'd0) return 3'd2;
        if (aop == 2'd1) return 3'd6;
        if (aop == 2'd3) return 3'd1;
        if (fn == 6'h20) return 3'd2;
        if (fn == 6'h22) return 3'd6;
        if (fn == 6'h24) return 3'd0;
        if (fn == 6'h25) return 3'd1;
        if (fn == 6'h2A) return 3'd7;
        return 3'd2;
    endfunction

    function automatic bit bad_funct(input bit [5:0] fn);
        return !(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
    endfunction

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        bit [31:0] va, vb;
        va = value_of(m.rs, m.rsd);
        vb = value_of(m.rt, m.rtd);
        chk("alu_a", alu_a, va);
        chk("alu_b", alu_b, m.src ? m.imm : vb);
        chk("store_data", ex_store_data, vb);
        chk("alu_operation", 32'(alu_operation), 32'(op_of(m.aop, m.fn)));
        chk("ex_illegal", 32'(ex_illegal), 32'(m.v && m.aop == 2'd2 && bad_funct(m.fn)));
        chk("ex_dest", 32'(ex_dest), 32'(m.dest));
        chk("ctrl", 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}),
            32'({m.v, m.rw, m.mr, m.mw, m.m2r, m.br}));
        chk("load_use", 32'(load_use_hazard),
            32'(m.mr && m.v && m.dest != 0 && (m.dest == id_rs || m.dest == id_rt)));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_alu_op = 0; id_funct = 0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
    endtask

    initial begin
        rst_n = 0; hold = 0; flush = 0;
        clear_id();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
        tick(); tick();
        @(negedge clk); rst_n = 1;
        tick();

        // R-type slt
        id_valid = 1; id_alu_op = 2'b10; id_funct = 6'h2A; id_rs = 1; id_rt = 2; id_rd = 3;
        id_rs_data = 32'h5; id_rt_data = 32'hFFFF_FFFF; id_reg_dst = 1; id_reg_write = 1;
        tick(); #1;
        chk("rtype_op", 32'(alu_operation), 32'h7);
        chk("rtype_a", alu_a, 32'h5);
        chk("rtype_b", alu_b, 32'hFFFF_FFFF);
        chk("rtype_dest", 32'(ex_dest), 32'd3);

        // forwarding priority
        clear_id();
        id_valid = 1; id_rs = 3; id_rt = 4; id_rs_data = 32'h11; id_rt_data = 32'h22;
        tick();
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h1234;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBEEF;
        #1 chk("fwd_exmem", alu_a, 32'h1234);
        exmem_rd = 0;
        #1 chk("fwd_memwb", alu_a, 32'hBEEF);
        memwb_rd = 4;
        #1 chk("fwd_b_store", ex_store_data, 32'hBEEF);
        tick();
        exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;

        // load-use
        clear_id();
        id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1; id_rs = 2; id_rt = 8;
        tick();
        clear_id();
        id_valid = 1; id_rs = 8; id_rt = 1;
        #1 chk("luh_rs", 32'(load_use_hazard), 32'd1);
        id_rs = 9; id_rt = 9;
        #1 chk("luh_none", 32'(load_use_hazard), 32'd0);
        clear_id();
        id_valid = 1; id_mem_read = 1; id_rt = 0;
        tick();
        id_rs = 0; id_rt = 0;
        #1 chk("luh_dest0", 32'(load_use_hazard), 32'd0);

        // hold then flush-with-hold
        clear_id();
        id_valid = 1; id_mem_write = 1; id_alu_src = 1; id_imm = 32'h40; id_rs = 5; id_rs_data = 32'h100;
        tick();
        hold = 1;
        clear_id(); id_imm = 32'h99;
        tick(); tick(); #1;
        chk("hold_b", alu_b, 32'h40);
        chk("hold_mw", 32'(ex_mem_write), 32'd1);
        chk("hold_v", 32'(ex_valid), 32'd1);
        flush = 1;
        tick(); #1;
        chk("flush_v", 32'(ex_valid), 32'd0);
        chk("flush_mw", 32'(ex_mem_write), 32'd0);
        hold = 0; flush = 0;

        // illegal funct, then bubble carrying the same funct
        clear_id();
        id_valid = 1; id_alu_op = 2'b10; id_funct = 6'h27;
        tick(); #1;
        chk("ill_op", 32'(alu_operation), 32'h2);
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        id_valid = 0;
        tick(); #1;
        chk("bubble_ill", 32'(ex_illegal), 32'd0);

        // async reset mid-cycle
        clear_id();
        id_valid = 1; id_alu_op = 2'b01; id_reg_write = 1;
        tick();
        #1 rst_n = 0;
        #1;
        chk("rst_v", 32'(ex_valid), 32'd0);
        chk("rst_rw", 32'(ex_reg_write), 32'd0);
        chk("rst_op", 32'(alu_operation), 32'h2);
        @(negedge clk); rst_n = 1;
        tick(); #1;
        chk("post_rst_v", 32'(ex_valid), 32'd1);
        chk("post_rst_op", 32'(alu_operation), 32'h6);

        // mixed traffic checked by the model only
        for (int i = 0; i < 300; i++) begin
            id_valid = 1'($urandom);
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
            id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
            id_alu_op = 2'($urandom);
            case ($urandom_range(0, 5))
                0: id_funct = 6'h20; 1: id_funct = 6'h22; 2: id_funct = 6'h24;
                3: id_funct = 6'h25; 4: id_funct = 6'h2A; default: id_funct = 6'h27;
            endcase
            {id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = 7'($urandom);
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
            tick();
        end
        hold = 0; flush = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
